// File: rtl/uart_tx_fsm_if.sv
// Handshake bundle between the UART transmit controller, its data source and the serializer.
interface uart_tx_fsm_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  ser_done;
  logic                  ser_data;
  logic                  SER_EN;
  logic                  BUSY;
  logic                  TX_OUT;

  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, ser_done, ser_data,
    input  SER_EN, BUSY, TX_OUT
  );

  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, ser_done, ser_data,
    output SER_EN, BUSY, TX_OUT
  );
endinterface

// File: rtl/uart_tx_fsm.sv
// UART transmit frame sequencer: start bit, 8 serialized data bits, optional parity, stop bit.
module uart_tx_fsm #(
  parameter int DATA_WIDTH = 8
) (
  input logic           CLK,
  input logic           RST,
  uart_tx_fsm_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t state;
  logic   par_en_q;
  logic   par_bit_q;
  logic   tx_out;
  logic   busy;
  logic   ser_en;

  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  // Parity is resolved at acceptance so later input changes cannot reach the frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.DATA_VALID) begin
            state     <= START;
            par_en_q  <= bus.PAR_EN;
            par_bit_q <= calc_parity(bus.P_DATA, bus.PAR_TYP);
          end
        end
        START:   state <= DATA;
        DATA: begin
          if (bus.ser_done) state <= par_en_q ? PARITY : STOP;
        end
        PARITY:  state <= STOP;
        STOP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    tx_out = 1'b1;
    busy   = 1'b0;
    ser_en = 1'b0;
    case (state)
      START: begin
        tx_out = 1'b0;
        busy   = 1'b1;
      end
      DATA: begin
        tx_out = bus.ser_data;
        busy   = 1'b1;
        ser_en = 1'b1;
      end
      PARITY: begin
        tx_out = par_bit_q;
        busy   = 1'b1;
      end
      STOP: begin
        busy   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.TX_OUT = tx_out;
  assign bus.BUSY   = busy;
  assign bus.SER_EN = ser_en;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Bench for uart_tx_fsm paired with a behavioural serializer; frames checked against a bit-list model.
module tb_uart_tx_fsm;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic inj_done = 1'b0;

  uart_tx_fsm_if #(.DATA_WIDTH(8)) bus();

  uart_tx_fsm #(.DATA_WIDTH(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  // Serializer: loads on acceptance, counter restarts at 0 whenever shifting begins.
  logic [7:0] sreg;
  logic [2:0] scnt;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sreg <= '0;
      scnt <= '0;
    end else if (bus.DATA_VALID && !bus.BUSY) begin
      sreg <= bus.P_DATA;
      scnt <= '0;
    end else if (bus.SER_EN) begin
      sreg <= {1'b0, sreg[7:1]};
      scnt <= scnt + 3'd1;
    end else begin
      scnt <= '0;
    end
  end
  assign bus.ser_data = sreg[0];
  assign bus.ser_done = (bus.SER_EN && scnt == 3'd7) || inj_done;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference frame: start 0, data LSB first, optional parity making the ones count even/odd, stop 1.
  function automatic void model_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                                      output logic [10:0] bits, output int len);
    int ones;
    ones = 0;
    bits = '0;
    for (int i = 0; i < 8; i++) begin
      bits[i+1] = d[i];
      ones += int'(d[i]);
    end
    len = 9;
    if (pen) begin
      bits[9] = ptyp ? (ones % 2 == 0) : (ones % 2 == 1);
      len = 10;
    end
    bits[len] = 1'b1;
    len++;
  endfunction

  task automatic run_frame(input logic [7:0] d, input logic pen, input logic ptyp, input bit inj,
                           output logic [10:0] got, output int busy_n, output int ser_n,
                           output logic idle_ok);
    @(posedge CLK); #1;
    bus.P_DATA = d; bus.PAR_EN = pen; bus.PAR_TYP = ptyp; bus.DATA_VALID = 1'b1;
    @(posedge CLK); #1;
    bus.DATA_VALID = 1'b0;
    got = '0; busy_n = 0; ser_n = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge CLK);
      if (bus.BUSY) begin
        if (busy_n < 11) got[busy_n] = bus.TX_OUT;
        busy_n++;
      end
      if (bus.SER_EN) ser_n++;
      if (inj) inj_done = (c == 0);
      if (c == 4) begin
        bus.P_DATA = ~d; bus.PAR_TYP = ~ptyp; bus.PAR_EN = ~pen;
      end
    end
    idle_ok = bus.TX_OUT & ~bus.BUSY & ~bus.SER_EN;
  endtask

  typedef struct {
    logic [7:0]  data;
    logic        pen;
    logic        ptyp;
    bit          inj;
    int          len;
    logic [10:0] exp_tx;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [10:0] got, exp;
    int          busy_n, ser_n, len;
    logic        idle_ok;
    logic [23:0] got_tx, got_busy, exp_tx2;
    logic [10:0] b1, b2;
    int          l1, l2, bad;
    logic [7:0]  rd;
    logic        rp, rt;

    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 11, 11'b1_0_10100101_0};
    vecs[1] = '{8'h01, 1'b1, 1'b1, 1'b0, 11, 11'b1_0_00000001_0};
    vecs[2] = '{8'h01, 1'b1, 1'b0, 1'b1, 11, 11'b1_1_00000001_0};
    vecs[3] = '{8'hFF, 1'b0, 1'b0, 1'b0, 10, 11'b0_1_11111111_0};
    vecs[4] = '{8'h3C, 1'b1, 1'b1, 1'b0, 11, 11'b1_1_00111100_0};
    vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b0, 11, 11'b1_1_00000000_0};
    vecs[6] = '{8'h80, 1'b0, 1'b1, 1'b1, 10, 11'b0_1_10000000_0};

    bus.P_DATA = '0; bus.DATA_VALID = 1'b0; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;

    // Reset asserted before any clock edge: outputs must settle to idle immediately.
    #2 RST = 1'b0;
    #1;
    check("reset_tx", 32'(bus.TX_OUT), 32'd1);
    check("reset_busy", 32'(bus.BUSY), 32'd0);
    check("reset_ser_en", 32'(bus.SER_EN), 32'd0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i].data, vecs[i].pen, vecs[i].ptyp, vecs[i].inj, got, busy_n, ser_n, idle_ok);
      check($sformatf("vec%0d_tx", i), 32'(got), 32'(vecs[i].exp_tx));
      check($sformatf("vec%0d_busy_len", i), 32'(busy_n), 32'(vecs[i].len));
      check($sformatf("vec%0d_ser_en_len", i), 32'(ser_n), 32'd8);
      check($sformatf("vec%0d_idle_after", i), 32'(idle_ok), 32'd1);
    end

    // DATA_VALID held through a frame while P_DATA changes: second frame after one idle cycle.
    @(posedge CLK); #1;
    bus.P_DATA = 8'hA5; bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b0; bus.DATA_VALID = 1'b1;
    @(posedge CLK); #1;
    for (int c = 0; c < 24; c++) begin
      @(negedge CLK);
      got_tx[c]   = bus.TX_OUT;
      got_busy[c] = bus.BUSY;
      if (c == 5) bus.P_DATA = 8'h3C;
      if (c == 13) bus.DATA_VALID = 1'b0;
    end
    model_frame(8'hA5, 1'b1, 1'b0, b1, l1);
    model_frame(8'h3C, 1'b1, 1'b0, b2, l2);
    exp_tx2 = '1;
    for (int k = 0; k < l1; k++) exp_tx2[k] = b1[k];
    for (int k = 0; k < l2; k++) exp_tx2[l1 + 1 + k] = b2[k];
    check("lockout_tx", 32'(got_tx), 32'(exp_tx2));
    check("lockout_busy", 32'(got_busy), 32'(24'b0_11111111111_0_11111111111));

    // Reset during the 4th DATA cycle aborts the frame without waiting for a clock edge.
    @(posedge CLK); #1;
    bus.P_DATA = 8'hA5; bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b0; bus.DATA_VALID = 1'b1;
    @(posedge CLK); #1;
    bus.DATA_VALID = 1'b0;
    for (int c = 0; c < 5; c++) @(negedge CLK);
    check("midrst_pre_busy", 32'(bus.BUSY), 32'd1);
    RST = 1'b0;
    #1;
    check("midrst_tx", 32'(bus.TX_OUT), 32'd1);
    check("midrst_busy", 32'(bus.BUSY), 32'd0);
    check("midrst_ser_en", 32'(bus.SER_EN), 32'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      if (bus.TX_OUT !== 1'b1 || bus.BUSY !== 1'b0) bad++;
    end
    check("midrst_release_idle", 32'(bad), 32'd0);

    // Randomized frames against the bit-list model.
    for (int n = 0; n < 20; n++) begin
      rd = 8'($urandom_range(0, 255));
      rp = 1'($urandom_range(0, 1));
      rt = 1'($urandom_range(0, 1));
      model_frame(rd, rp, rt, exp, len);
      run_frame(rd, rp, rt, 1'b0, got, busy_n, ser_n, idle_ok);
      check($sformatf("rand%0d_tx_d%02h_p%0d_t%0d", n, rd, rp, rt), 32'(got), 32'(exp));
      check($sformatf("rand%0d_busy_len", n), 32'(busy_n), 32'(len));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_fsm.md
UART_TX_FSM -- requirements
Module: uart_tx_fsm

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of P_DATA used for parity; the bit count per frame is fixed at 8 by the serializer's ser_done.
REQ-002 SHALL have CLK  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have RST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have P_DATA  input  DATA_WIDTH  parallel byte; used only to compute parity at acceptance.
REQ-005 SHALL have DATA_VALID  input  1  request to transmit P_DATA.
REQ-006 SHALL have PAR_EN  input  1  1 = insert a parity bit.
REQ-007 SHALL have PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 SHALL have ser_done  input  1  serializer done flag; high during the 8th shift cycle.
REQ-009 SHALL have ser_data  input  1  serializer serial bit (LSB first).
REQ-010 SHALL have SER_EN  output  1  shift enable to the serializer.
REQ-011 SHALL have BUSY  output  1  frame in progress; drives the serializer Busy input.
REQ-012 SHALL have TX_OUT  output  1  UART line; idle high.

Function
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP in a single state register.
REQ-014 IDLE: TX_OUT=1, BUSY=0, SER_EN=0; on DATA_VALID=1 at an edge -> START, else stay.
REQ-015 On acceptance in IDLE: SHALL latch PAR_EN, PAR_TYP and the parity bit (XOR-reduce of P_DATA, inverted when PAR_TYP=1); later changes to these inputs do not affect the current frame.
REQ-016 START: TX_OUT=0, BUSY=1, SER_EN=0; unconditionally -> DATA after 1 cycle.
REQ-017 DATA: TX_OUT=ser_data, BUSY=1, SER_EN=1; when ser_done=1 -> PARITY if latched PAR_EN=1, else -> STOP; otherwise stay.
REQ-018 DATA SHALL therefore last exactly 8 cycles when paired with the serializer, because its counter starts at 0 on SER_EN rise.
REQ-019 PARITY: TX_OUT=latched parity bit, BUSY=1, SER_EN=0; -> STOP after 1 cycle.
REQ-020 STOP: TX_OUT=1, BUSY=1, SER_EN=0; -> IDLE after 1 cycle unconditionally.
REQ-021 SHALL ignore DATA_VALID in every state except IDLE; there is no queuing and no back-to-back frames, so at least 1 IDLE cycle separates frames.
REQ-022 Frame length from the START cycle to the last STOP cycle SHALL be 11 cycles with PAR_EN=1 and 10 cycles with PAR_EN=0.
REQ-023 TX_OUT, BUSY and SER_EN SHALL be combinational decodes of the registered state only (plus ser_data in DATA); no output depends on DATA_VALID.
REQ-024 Unused or illegal state encodings SHALL recover to IDLE on the next edge.
REQ-025 ser_done outside DATA SHALL be ignored.

Reset
REQ-026 RST=0 SHALL force state=IDLE and the parity/config latches to 0 immediately; TX_OUT=1, BUSY=0, SER_EN=0 while reset is held.
REQ-027 Reset asserted mid-frame SHALL abort the frame; the first edge after release runs from IDLE.

Verification (bench instantiates uart_tx_fsm with the existing serializer)
REQ-028 Even parity frame: P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, DATA_VALID pulsed 1 cycle -> TX_OUT per cycle 0,1,0,1,0,0,1,0,1,0,1, then idle 1; BUSY high for exactly 11 cycles.
REQ-029 Odd parity: P_DATA=0x01, PAR_TYP=1 -> parity bit 0; repeat with PAR_TYP=0 -> parity bit 1.
REQ-030 No parity: P_DATA=0xFF, PAR_EN=0 -> TX_OUT 0,1,1,1,1,1,1,1,1,1; BUSY high for 10 cycles; SER_EN high for exactly 8 cycles.
REQ-031 Busy lockout: DATA_VALID held high with P_DATA changed to 0x3C mid-frame -> current frame bits unchanged; next frame starts only after 1 IDLE cycle and carries 0x3C.
REQ-032 Reset mid-frame: RST=0 during the 4th DATA cycle -> TX_OUT=1 and BUSY=0 asynchronously; after release with no DATA_VALID, TX_OUT stays 1.
REQ-033 Config stability: toggle PAR_TYP during DATA of a 0xA5 frame -> parity bit follows the value latched at acceptance (0).
